nbit_decoder_pipe: RTL and testbench

//  Registered N-to-2**N decoder with valid/ready handshakes on both sides.

---
 rtl/nbit_decoder_pipe_if.sv | 25 ++
 rtl/nbit_decoder_pipe.sv | 107 ++++++++++
 tb/tb_nbit_decoder_pipe.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/nbit_decoder_pipe_if.sv
// Valid/ready bundle for nbit_decoder_pipe: code/mode on the input side, decoded vector on the output side.
interface nbit_decoder_pipe_if #(
    parameter int N = 3
);
    localparam int W = 1 << N;

    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] a;
    logic [1:0]   mode;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] y;
    logic         err;

    modport master (
        output in_valid, a, mode, out_ready,
        input  in_ready, out_valid, y, err
    );

    modport slave (
        input  in_valid, a, mode, out_ready,
        output in_ready, out_valid, y, err
    );
endinterface

// File: rtl/nbit_decoder_pipe.sv
// Registered N-to-2**N decoder (one-hot LSB/MSB, thermometer) with an output register
// plus one skid entry so a decode per cycle is sustained under backpressure.
module nbit_decoder_pipe #(
    parameter int N          = 3,
    parameter bit ACTIVE_LOW = 1'b0
) (
    input  logic               clk,
    input  logic               rst,
    nbit_decoder_pipe_if.slave bus
);
    localparam int             W    = 1 << N;
    localparam logic [W-1:0]   IDLE = ACTIVE_LOW ? {W{1'b1}} : {W{1'b0}};
    localparam logic [W-1:0]   ONE  = {{(W-1){1'b0}}, 1'b1};

    // Returns {err, y} with output polarity already applied; err is never inverted.
    function automatic logic [W:0] decode(input logic [N-1:0] code, input logic [1:0] sel);
        logic [W-1:0] vec;
        logic         bad;
        vec = {W{1'b0}};
        bad = 1'b0;
        case (sel)
            2'd0: vec = ONE << code;
            // ~code equals W-1-code for an N-bit code
            2'd1: vec = ONE << (~code);
            2'd2: begin
                for (int i = 0; i < W; i++) begin
                    vec[i] = (i <= int'(code));
                end
            end
            default: bad = 1'b1;
        endcase
        return {bad, vec ^ IDLE};
    endfunction

    logic         accept_s;
    logic [W:0]   dec_s;
    logic         out_valid_r, out_valid_s;
    logic [W-1:0] out_y_r, out_y_s;
    logic         out_err_r, out_err_s;
    logic         sk_valid_r, sk_valid_s;
    logic [W-1:0] sk_y_r, sk_y_s;
    logic         sk_err_r, sk_err_s;
    logic         in_ready_r, in_ready_s;

    // Next-state of the output register and skid entry; the skid always drains first.
    always_comb begin
        accept_s    = bus.in_valid && in_ready_r;
        dec_s       = decode(bus.a, bus.mode);
        out_valid_s = out_valid_r;
        out_y_s     = out_y_r;
        out_err_s   = out_err_r;
        sk_valid_s  = sk_valid_r;
        sk_y_s      = sk_y_r;
        sk_err_s    = sk_err_r;
        if (!out_valid_r || bus.out_ready) begin
            if (sk_valid_r) begin
                out_valid_s = 1'b1;
                out_y_s     = sk_y_r;
                out_err_s   = sk_err_r;
                sk_valid_s  = 1'b0;
                sk_y_s      = IDLE;
                sk_err_s    = 1'b0;
            end else if (accept_s) begin
                out_valid_s = 1'b1;
                out_y_s     = dec_s[W-1:0];
                out_err_s   = dec_s[W];
            end else begin
                out_valid_s = 1'b0;
                out_y_s     = IDLE;
                out_err_s   = 1'b0;
            end
        end else if (accept_s) begin
            sk_valid_s = 1'b1;
            sk_y_s     = dec_s[W-1:0];
            sk_err_s   = dec_s[W];
        end else begin
            sk_valid_s = sk_valid_r;
        end
        in_ready_s = !sk_valid_s;
    end

    // State registers; reset drops any held transaction.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_r <= 1'b0;
            out_y_r     <= IDLE;
            out_err_r   <= 1'b0;
            sk_valid_r  <= 1'b0;
            sk_y_r      <= IDLE;
            sk_err_r    <= 1'b0;
            in_ready_r  <= 1'b0;
        end else begin
            out_valid_r <= out_valid_s;
            out_y_r     <= out_y_s;
            out_err_r   <= out_err_s;
            sk_valid_r  <= sk_valid_s;
            sk_y_r      <= sk_y_s;
            sk_err_r    <= sk_err_s;
            in_ready_r  <= in_ready_s;
        end
    end

    assign bus.in_ready  = in_ready_r;
    assign bus.out_valid = out_valid_r;
    assign bus.y         = out_y_r;
    assign bus.err       = out_err_r;
endmodule

// File: tb/tb_nbit_decoder_pipe.sv
// Scoreboard bench for nbit_decoder_pipe: main N=3 instance plus ACTIVE_LOW, N=1 and N=6 instances.
module tb_nbit_decoder_pipe;
    logic clk;
    logic rst;
    int   n_vec;
    int   n_err;
    logic [8:0] q[$];
    logic [7:0] got[$];

    nbit_decoder_pipe_if #(.N(3)) m ();
    nbit_decoder_pipe_if #(.N(3)) al ();
    nbit_decoder_pipe_if #(.N(1)) n1 ();
    nbit_decoder_pipe_if #(.N(6)) n6 ();

    nbit_decoder_pipe #(.N(3), .ACTIVE_LOW(1'b0)) u_main (.clk(clk), .rst(rst), .bus(m.slave));
    nbit_decoder_pipe #(.N(3), .ACTIVE_LOW(1'b1)) u_al   (.clk(clk), .rst(rst), .bus(al.slave));
    nbit_decoder_pipe #(.N(1), .ACTIVE_LOW(1'b0)) u_n1   (.clk(clk), .rst(rst), .bus(n1.slave));
    nbit_decoder_pipe #(.N(6), .ACTIVE_LOW(1'b0)) u_n6   (.clk(clk), .rst(rst), .bus(n6.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference decode for N=3, active-high: returns {err, y}.
    function automatic logic [8:0] model(input logic [2:0] a, input logic [1:0] mode);
        case (mode)
            2'd0:    return {1'b0, 8'h01 << a};
            2'd1:    return {1'b0, 8'h80 >> a};
            2'd2:    return {1'b0, 8'hFF >> (3'd7 - a)};
            default: return {1'b1, 8'h00};
        endcase
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock on the main instance: update the scoreboard, then check outputs #1 after the edge.
    task automatic cycle();
        logic acc;
        logic xfer;
        acc  = (m.in_valid === 1'b1) && (m.in_ready === 1'b1) && !rst;
        xfer = (m.out_valid === 1'b1) && (m.out_ready === 1'b1) && !rst;
        if (xfer && q.size() > 0) void'(q.pop_front());
        if (acc) q.push_back(model(m.a, m.mode));
        if (rst) q.delete();
        @(posedge clk);
        #1;
        if (rst) begin
            chk("rst_out_valid", 64'(m.out_valid), 64'd0);
            chk("rst_in_ready", 64'(m.in_ready), 64'd0);
            chk("rst_y", 64'(m.y), 64'd0);
            chk("rst_err", 64'(m.err), 64'd0);
        end else begin
            chk("in_ready", 64'(m.in_ready), 64'(q.size() < 2));
            chk("out_valid", 64'(m.out_valid), 64'(q.size() > 0));
            if (q.size() > 0) begin
                chk("y", 64'(m.y), 64'(q[0][7:0]));
                chk("err", 64'(m.err), 64'(q[0][8]));
            end else begin
                chk("idle_y", 64'(m.y), 64'd0);
                chk("idle_err", 64'(m.err), 64'd0);
            end
        end
    endtask

    initial begin
        logic [2:0] t_a[6];
        logic [1:0] t_m[6];
        logic [7:0] t_y[6];
        logic       acc_now;
        n_vec = 0;
        n_err = 0;
        t_a = '{3'd5, 3'd5, 3'd5, 3'd0, 3'd7, 3'd2};
        t_m = '{2'd0, 2'd1, 2'd2, 2'd2, 2'd2, 2'd3};
        t_y = '{8'h20, 8'h04, 8'h3F, 8'h01, 8'hFF, 8'h00};

        rst = 1'b1;
        m.in_valid = 1'b1;  m.a = 3'd5; m.mode = 2'd0; m.out_ready = 1'b0;
        al.in_valid = 1'b0; al.a = 3'd0; al.mode = 2'd0; al.out_ready = 1'b1;
        n1.in_valid = 1'b0; n1.a = 1'd0; n1.mode = 2'd0; n1.out_ready = 1'b1;
        n6.in_valid = 1'b0; n6.a = 6'd0; n6.mode = 2'd0; n6.out_ready = 1'b1;

        // Reset held three cycles with in_valid asserted
        for (int i = 0; i < 3; i++) cycle();
        chk("al_rst_y", 64'(al.y), 64'h0FF);
        chk("al_rst_valid", 64'(al.out_valid), 64'd0);
        rst = 1'b0;
        m.in_valid = 1'b0;
        cycle();
        chk("ready_after_rst", 64'(m.in_ready), 64'd1);

        // Every mode, one transaction at a time
        m.out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            m.in_valid = 1'b1; m.a = t_a[i]; m.mode = t_m[i];
            cycle();
            chk("mode_y", 64'(m.y), 64'(t_y[i]));
            chk("mode_err", 64'(m.err), 64'(t_m[i] == 2'd3));
            m.in_valid = 1'b0;
            cycle();
        end

        // Backpressure: fill OUT and skid, third request blocked
        m.out_ready = 1'b0;
        m.in_valid = 1'b1; m.mode = 2'd0;
        m.a = 3'd1; cycle();
        m.a = 3'd2; cycle();
        m.a = 3'd3; cycle();
        chk("bp_out", 64'(m.y), 64'h02);
        chk("bp_ready", 64'(m.in_ready), 64'd0);
        m.out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (m.out_valid === 1'b1) got.push_back(m.y);
            acc_now = (m.in_valid === 1'b1) && (m.in_ready === 1'b1);
            cycle();
            if (acc_now) m.in_valid = 1'b0;
        end
        chk("bp_count", 64'(got.size()), 64'd3);
        if (got.size() == 3) begin
            chk("bp_order0", 64'(got[0]), 64'h02);
            chk("bp_order1", 64'(got[1]), 64'h04);
            chk("bp_order2", 64'(got[2]), 64'h08);
        end

        // Back-to-back throughput
        m.in_valid = 1'b1;
        for (int i = 0; i < 16; i++) begin
            m.a = 3'($urandom_range(0, 7));
            m.mode = 2'($urandom_range(0, 3));
            cycle();
        end
        m.in_valid = 1'b0;
        cycle();

        // Random valid/ready traffic
        for (int i = 0; i < 60; i++) begin
            m.in_valid = 1'($urandom_range(0, 1));
            m.out_ready = 1'($urandom_range(0, 1));
            m.a = 3'($urandom_range(0, 7));
            m.mode = 2'($urandom_range(0, 3));
            cycle();
        end
        m.in_valid = 1'b0; m.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) cycle();

        // Mid-operation reset with OUT and skid both full
        m.out_ready = 1'b0; m.in_valid = 1'b1;
        m.a = 3'd4; m.mode = 2'd0; cycle();
        m.a = 3'd6; m.mode = 2'd2; cycle();
        m.in_valid = 1'b0;
        chk("mid_full_ready", 64'(m.in_ready), 64'd0);
        rst = 1'b1; cycle();
        rst = 1'b0; cycle();
        m.out_ready = 1'b1;
        cycle();
        cycle();
        m.in_valid = 1'b1; m.a = 3'd7; m.mode = 2'd1; cycle();
        chk("post_rst_y", 64'(m.y), 64'h01);
        m.in_valid = 1'b0;
        cycle();

        // Polarity and other widths
        al.in_valid = 1'b1; al.a = 3'd3; al.mode = 2'd0;
        n1.in_valid = 1'b1; n1.a = 1'd1; n1.mode = 2'd1;
        n6.in_valid = 1'b1; n6.a = 6'd63; n6.mode = 2'd0;
        cycle();
        chk("al_m0_y", 64'(al.y), 64'hF7);
        chk("al_m0_err", 64'(al.err), 64'd0);
        chk("n1_m1_y", 64'(n1.y), 64'h1);
        chk("n6_m0_y", 64'(n6.y), 64'h8000_0000_0000_0000);
        al.a = 3'd2; al.mode = 2'd3;
        n1.a = 1'd1; n1.mode = 2'd2;
        n6.a = 6'd40; n6.mode = 2'd2;
        cycle();
        chk("al_m3_y", 64'(al.y), 64'hFF);
        chk("al_m3_err", 64'(al.err), 64'd1);
        chk("n1_m2_y", 64'(n1.y), 64'h3);
        chk("n6_m2_y", 64'(n6.y), 64'h1FF_FFFF_FFFF);
        al.in_valid = 1'b0; n1.in_valid = 1'b0; n6.in_valid = 1'b0;
        cycle();
        chk("al_idle_y", 64'(al.y), 64'hFF);
        chk("al_idle_valid", 64'(al.out_valid), 64'd0);
        chk("n6_idle_y", 64'(n6.y), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
